// File: rtl/fm0_byte_encoder.sv
// FM0 backscatter byte encoder: raw preamble, then FIFO bytes FM0-encoded MSB first,
// closed by the FM0 dummy '1' bit. Pops the next byte in the last clock of each byte.
module fm0_byte_encoder #(
  parameter int unsigned         CYCLES_PER_HALF = 4,
  parameter int unsigned         PRE_LEN         = 12,
  parameter logic [PRE_LEN-1:0]  PREAMBLE        = 12'b110100100011
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_en,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] byte_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DUMMY    = 2'd3
  } state_t;

  localparam logic [7:0]  HC_LAST  = 8'(CYCLES_PER_HALF - 1);
  localparam logic [4:0]  PRE_LAST = 5'(PRE_LEN - 1);
  localparam logic [31:0] PRE_VEC  = 32'(PREAMBLE);

  state_t     state_r, state_s;
  logic [7:0] hc_r, hc_s;
  logic [4:0] pidx_r, pidx_s;
  logic [2:0] bit_r, bit_s;
  logic       half_r, half_s;
  logic [7:0] shift_r, shift_s;
  logic       level_r, level_s;
  logic       busy_r, busy_s;
  logic [7:0] count_r, count_s;
  logic       read_s;
  logic       done_s;
  logic       half_end_s;

  // Next-state, datapath updates and the two strobes decoded from the current state.
  always_comb begin
    state_s    = state_r;
    hc_s       = hc_r;
    pidx_s     = pidx_r;
    bit_s      = bit_r;
    half_s     = half_r;
    shift_s    = shift_r;
    level_s    = level_r;
    busy_s     = busy_r;
    count_s    = count_r;
    read_s     = 1'b0;
    done_s     = 1'b0;
    half_end_s = (hc_r == HC_LAST);

    if (state_r == S_IDLE) begin
      hc_s = 8'd0;
    end else if (half_end_s) begin
      hc_s = 8'd0;
    end else begin
      hc_s = hc_r + 8'd1;
    end

    case (state_r)
      S_IDLE: begin
        level_s = 1'b0;
        if (tx_start && !fifo_empty) begin
          state_s = S_PREAMBLE;
          busy_s  = 1'b1;
          count_s = 8'd0;
          pidx_s  = PRE_LAST;
          half_s  = 1'b0;
          level_s = PRE_VEC[PRE_LAST];
        end else begin
          busy_s = 1'b0;
        end
      end

      S_PREAMBLE: begin
        if (!half_end_s) begin
          level_s = level_r;
        end else if (pidx_r != 5'd0) begin
          pidx_s  = pidx_r - 5'd1;
          level_s = PRE_VEC[pidx_r - 5'd1];
        end else if (!fifo_empty) begin
          // Prefetch the first byte; its first bit starts with an inversion.
          read_s  = 1'b1;
          shift_s = fifo_data;
          bit_s   = 3'd7;
          half_s  = 1'b0;
          level_s = ~level_r;
          state_s = S_DATA;
        end else begin
          half_s  = 1'b0;
          level_s = ~level_r;
          state_s = S_DUMMY;
        end
      end

      S_DATA: begin
        if (!half_end_s) begin
          level_s = level_r;
        end else if (!half_r) begin
          half_s  = 1'b1;
          level_s = shift_r[7] ? level_r : ~level_r;
        end else if (bit_r != 3'd0) begin
          bit_s   = bit_r - 3'd1;
          shift_s = {shift_r[6:0], 1'b0};
          half_s  = 1'b0;
          level_s = ~level_r;
        end else begin
          count_s = (count_r == 8'hFF) ? count_r : count_r + 8'd1;
          half_s  = 1'b0;
          level_s = ~level_r;
          if (!fifo_empty) begin
            read_s  = 1'b1;
            shift_s = fifo_data;
            bit_s   = 3'd7;
          end else begin
            state_s = S_DUMMY;
          end
        end
      end

      S_DUMMY: begin
        if (!half_end_s) begin
          level_s = level_r;
        end else if (!half_r) begin
          half_s = 1'b1;
        end else begin
          done_s  = 1'b1;
          state_s = S_IDLE;
          busy_s  = 1'b0;
          half_s  = 1'b0;
          level_s = 1'b0;
        end
      end

      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
        level_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      hc_r    <= 8'd0;
      pidx_r  <= 5'd0;
      bit_r   <= 3'd0;
      half_r  <= 1'b0;
      shift_r <= 8'd0;
      level_r <= 1'b0;
      busy_r  <= 1'b0;
      count_r <= 8'd0;
    end else begin
      state_r <= state_s;
      hc_r    <= hc_s;
      pidx_r  <= pidx_s;
      bit_r   <= bit_s;
      half_r  <= half_s;
      shift_r <= shift_s;
      level_r <= level_s;
      busy_r  <= busy_s;
      count_r <= count_s;
    end
  end

  assign fifo_read_en = read_s;
  assign tx_done      = done_s;
  assign tx_out       = level_r;
  assign tx_busy      = busy_r;
  assign byte_count   = count_r;

endmodule

// File: tb/tb_fm0_byte_encoder.sv
// Scoreboard bench for fm0_byte_encoder: a frame-level model queues expected half-bit
// levels, pop offsets and byte counts; a negedge monitor compares them against the DUT.
module tb_fm0_byte_encoder;

  localparam int          CPH = 2;
  localparam int          PL  = 12;
  localparam logic [11:0] PRE = 12'b110100100011;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_start = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_en, tx_out, tx_busy, tx_done;
  logic [7:0] byte_count;

  logic [7:0] mem [0:511];
  int         wr = 0;
  int         rd = 0;
  logic       fifo_clr = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];
  int   rd_q[$];
  int   bc_q[$];
  int   idle_bc = 0;
  int   offset = 0;
  logic prev_rd = 1'b0;
  bit   mon_en = 1'b0;

  fm0_byte_encoder #(.CYCLES_PER_HALF(CPH), .PRE_LEN(PL), .PREAMBLE(PRE)) dut (
    .clock(clock), .reset_n(reset_n), .tx_start(tx_start), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read_en(fifo_read_en), .tx_out(tx_out),
    .tx_busy(tx_busy), .tx_done(tx_done), .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  assign fifo_empty = (wr == rd);
  assign fifo_data  = mem[rd[8:0]];

  always @(posedge clock) begin
    if (fifo_clr) rd <= wr;
    else if (fifo_read_en && !fifo_empty) rd <= rd + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not expected at %0t", name, $time);
  endtask

  task automatic write_byte(input logic [7:0] b);
    logic [8:0] a;
    a = 9'(wr);
    mem[a] = b;
    wr++;
  endtask

  task automatic push_half(input logic lvl);
    for (int c = 0; c < CPH; c++) exp_q.push_back(lvl);
  endtask

  // Frame model: raw preamble, FM0 bits (invert at each bit start, again mid-bit for '0'),
  // then the dummy '1'. Every byte now in the FIFO is sent.
  task automatic push_frame(input int n);
    logic       lvl;
    logic [7:0] b;
    logic [8:0] a;
    for (int i = PL - 1; i >= 0; i--) push_half(PRE[i]);
    lvl = PRE[0];
    for (int k = 0; k < n; k++) begin
      a = 9'(rd + k);
      b = mem[a];
      rd_q.push_back(PL * CPH - 1 + k * 16 * CPH);
      for (int j = 7; j >= 0; j--) begin
        lvl = ~lvl;
        push_half(lvl);
        if (!b[j]) lvl = ~lvl;
        push_half(lvl);
      end
    end
    lvl = ~lvl;
    push_half(lvl);
    push_half(lvl);
    bc_q.push_back((n > 255) ? 255 : n);
  endtask

  // Called at posedge+2; returns in cycle 0 of the accepted frame.
  task automatic start_frame();
    push_frame(wr - rd);
    tx_start = 1'b1;
    @(posedge clock); #2;
    tx_start = 1'b0;
  endtask

  task automatic wait_frame();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || tx_busy) && b < 20000) begin
      @(posedge clock);
      b++;
    end
    #2;
    if (b >= 20000) fail("frame_timeout");
  endtask

  // Monitor: compares every busy cycle against the queued model and idle cycles against zeros.
  initial begin
    int e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (tx_busy) begin
          if (offset == 0) check("bc_at_start", 32'(byte_count), 32'd0);
          if (exp_q.size() == 0) fail("unexpected_busy");
          else check("tx_out", 32'(tx_out), 32'(exp_q.pop_front()));
          if (fifo_read_en) begin
            if (rd_q.size() == 0) fail("unexpected_pop");
            else check("pop_offset", 32'(offset), 32'(rd_q.pop_front()));
            check("pop_consecutive", 32'(prev_rd), 32'd0);
            check("pop_nonempty", 32'(fifo_empty), 32'd0);
          end
          if (tx_done) begin
            if (bc_q.size() == 0) fail("unexpected_done");
            else begin
              e = bc_q.pop_front();
              check("bc_at_done", 32'(byte_count), 32'(e));
              idle_bc = e;
            end
            check("pops_left", 32'(rd_q.size()), 32'd0);
            check("levels_left", 32'(exp_q.size()), 32'd0);
          end
          offset++;
        end else begin
          check("idle_tx_out", 32'(tx_out), 32'd0);
          check("idle_done", 32'(tx_done), 32'd0);
          check("idle_pop", 32'(fifo_read_en), 32'd0);
          check("idle_bc", 32'(byte_count), 32'(idle_bc));
          offset = 0;
        end
        prev_rd = fifo_read_en;
      end
    end
  end

  initial begin
    // Reset held for three edges with a start request and a byte waiting.
    write_byte(8'h5A);
    tx_start = 1'b1;
    @(posedge clock); #2;
    mon_en = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    check("reset_no_pop", 32'(rd), 32'd0);
    tx_start = 1'b0;
    reset_n  = 1'b1;
    fifo_clr = 1'b1;
    @(posedge clock); #2;
    fifo_clr = 1'b0;

    // Single byte 0xA5.
    write_byte(8'hA5);
    start_frame();
    wait_frame();

    // Back-to-back 0x00, 0xFF.
    write_byte(8'h00);
    write_byte(8'hFF);
    start_frame();
    wait_frame();

    // Start with an empty FIFO is ignored.
    tx_start = 1'b1;
    @(posedge clock); #2;
    tx_start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("empty_start_busy", 32'(tx_busy), 32'd0);

    // Abort with reset during bit 3 of the first byte.
    write_byte(8'hC3);
    write_byte(8'h3C);
    start_frame();
    repeat (PL * CPH + 17) @(posedge clock);
    #2;
    reset_n = 1'b0;
    @(posedge clock); #2;
    exp_q.delete();
    rd_q.delete();
    bc_q.delete();
    idle_bc  = 0;
    reset_n  = 1'b1;
    fifo_clr = 1'b1;
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_tx_out", 32'(tx_out), 32'd0);
    @(posedge clock); #2;
    fifo_clr = 1'b0;
    write_byte(8'h96);
    start_frame();
    wait_frame();

    // Starts during DATA and in the tx_done cycle are ignored.
    write_byte(8'h71);
    start_frame();
    repeat (PL * CPH + 5) @(posedge clock);
    #2;
    tx_start = 1'b1;
    @(posedge clock); #2;
    tx_start = 1'b0;
    repeat ((PL + 16) * CPH + 1 - (PL * CPH + 6)) @(posedge clock);
    #2;
    write_byte(8'hE4);
    repeat (2) @(posedge clock);
    #2;
    check("done_cycle_flag", 32'(tx_done), 32'd1);
    tx_start = 1'b1;
    @(posedge clock); #2;
    tx_start = 1'b0;
    check("busy_start_ignored", 32'(tx_busy), 32'd0);
    @(posedge clock); #2;
    start_frame();
    wait_frame();

    // Random frames of 1..4 bytes.
    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) write_byte(8'($urandom_range(0, 255)));
      start_frame();
      wait_frame();
      repeat (int'($urandom_range(0, 3))) @(posedge clock);
      #2;
    end

    // Long frame: byte_count saturates at 255.
    for (int j = 0; j < 260; j++) write_byte(8'($urandom_range(0, 255)));
    start_frame();
    wait_frame();
    @(posedge clock); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fm0_byte_encoder.md
Name: fm0_byte_encoder

Overview:
- Downstream consumer of the 8-bit single-clock FIFO in the tag backscatter transmit path.
- On a start request it sends a fixed preamble, then pops bytes from the FIFO and FM0-encodes them MSB-first onto a single-bit backscatter line.
- It fetches bytes seamlessly until the FIFO runs empty, then appends the FM0 end-of-signalling dummy '1' bit and returns to idle.

Parameters:
- CYCLES_PER_HALF, 4, clocks per FM0 half-bit (legal range 2..255).
- PRE_LEN, 12, number of preamble half-bit levels (legal range 1..32).
- PREAMBLE, 12'b110100100011, raw preamble half-bit levels, sent MSB first exactly as given (no encoding).

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- tx_start  in  1  single-cycle frame request.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO read data; valid combinationally only while fifo_read_en=1.
- fifo_read_en  out  1  FIFO pop strobe; never high for more than one consecutive cycle.
- tx_out  out  1  FM0 backscatter level.
- tx_busy  out  1  high from accepted start until tx_done.
- tx_done  out  1  one-cycle pulse when the frame completes.
- byte_count  out  8  bytes sent in the current or last frame; saturates at 255.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; all outputs 0 after that edge, including tx_out, fifo_read_en, tx_busy, tx_done and byte_count; internal counters 0. A reset mid-frame aborts the frame with no dummy bit and no tx_done pulse.
- States: IDLE, PREAMBLE, DATA, DUMMY.
- Timing unit: a half-bit counter hc runs 0..CYCLES_PER_HALF-1, and each half-bit level is held for exactly CYCLES_PER_HALF clocks.
- IDLE:
  - tx_out=0.
  - tx_start=1 with fifo_empty=0 → PREAMBLE at the next edge; tx_busy=1 and byte_count=0 from that edge.
  - tx_start with fifo_empty=1 is ignored.
  - tx_start outside IDLE is ignored.
- PREAMBLE:
  - Drives PREAMBLE[PRE_LEN-1] down to PREAMBLE[0], one level per half-bit.
  - In the final clock of the last preamble half-bit, fifo_read_en=1 if fifo_empty=0. At that edge fifo_data is loaded into the shift register and the state goes to DATA.
  - If fifo_empty=1 at that cycle, the state goes directly to DUMMY.
- DATA, FM0 encoding (level = current tx_out):
  - At the start of every bit, tx_out inverts relative to the previous half-bit level.
  - Data '0': tx_out inverts again at mid-bit.
  - Data '1': tx_out holds for both halves.
- DATA, byte handling:
  - Bits are sent MSB first; bit index runs 7..0.
  - In the final clock of the second half of bit 0, the same prefetch rule applies: a pop and load keeps the encoder in DATA with no idle gap and increments byte_count; otherwise the state goes to DUMMY (byte_count still increments).
- DUMMY:
  - One FM0 '1' bit: invert, hold two half-bits.
  - At its final clock, tx_done=1 for that cycle. At the next edge tx_busy=0, state=IDLE and tx_out=0.
- Simultaneous events:
  - A FIFO write in the same cycle as the prefetch check does not count; only the sampled fifo_empty decides.
  - tx_start in the same cycle as tx_done is ignored.
- byte_count holds its value in IDLE until the next accepted start.

Test Plan:
- Reset check: hold reset_n=0 for 3 clocks while tx_start=1 → all outputs stay 0 and no pop occurs.
- Single byte (CYCLES_PER_HALF=2, FIFO holds 0xA5), pulse tx_start:
  - tx_busy rises on the next edge.
  - Preamble levels 110100100011 are sent over 24 clocks.
  - Exactly one fifo_read_en pulse, in the last preamble clock.
  - Data half-levels are 00 10 11 01 01 00 10 11, then dummy 00.
  - tx_done pulses in the last dummy clock; byte_count=1; tx_out=0 in IDLE.
- Back-to-back bytes (FIFO holds 0x00, 0xFF):
  - Both pops are single-cycle and there is no gap between bytes.
  - 0x00 encodes as alternating half-levels (inversion every half-bit).
  - byte_count=2 at tx_done.
- Empty FIFO: tx_start with fifo_empty=1 → no state change, tx_busy stays 0 and no fifo_read_en.
- Abort: pull reset_n low during bit 3 of a byte → next edge all outputs 0, no tx_done. After release, a new tx_start runs a full frame correctly.
- Busy start: tx_start pulses during DATA and in the tx_done cycle → both ignored; only one frame is transmitted.
